// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg
// Shared definitions for the multi-channel timer: the per-channel register
// map, CONTROL/STATUS field layouts and bit positions, and a helper that
// packs a CONTROL register into its 32-bit bus view.
// Optional feature macro: MULTI_TIMER_PRESCALER_EN (enables CONTROL[15:8]).
// Ports: none (package).
package multi_timer_pkg;

    localparam int REGISTER_ADDRESS_WIDTH = 2;

    // Field bit positions within the 32-bit bus view of each register
    localparam int COUNT_ENABLE_BIT = 0;
    localparam int CYCLIC_MODE_BIT  = 1;
    localparam int IRQ_ENABLE_BIT   = 2;
    localparam int PRESCALE_LSB     = 8;
    localparam int PRESCALE_WIDTH   = 8;
    localparam int EVENT_FLAG_BIT   = 0;

    typedef enum logic [REGISTER_ADDRESS_WIDTH-1:0] {
        CONTROL = 2'd0,
        STATUS  = 2'd1,
        REFILL  = 2'd2,
        COUNT   = 2'd3
    } local_address_t;

    typedef struct packed {
        logic [PRESCALE_WIDTH-1:0] prescale;
        logic                      irq_enable;
        logic                      cyclic_mode;
        logic                      count_enable;
    } control_reg_t;

    typedef struct packed {
        logic event_flag;
    } status_reg_t;

    // Unused CONTROL bits always read as zero
    function automatic logic [31:0] control_to_word(input control_reg_t c);
        logic [31:0] word;
        word                                     = '0;
        word[COUNT_ENABLE_BIT]                   = c.count_enable;
        word[CYCLIC_MODE_BIT]                    = c.cyclic_mode;
        word[IRQ_ENABLE_BIT]                     = c.irq_enable;
        word[PRESCALE_LSB +: PRESCALE_WIDTH]     = c.prescale;
        return word;
    endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if
// Zero-wait-state register bus used by the multi-channel timer.
// Signals: valid (request), ready (acknowledge), address (word index),
// wstrobe (byte enables, all zero = read), wdata, rdata.
// Modports: master drives requests, slave (the timer) answers them.
interface multi_timer_if
    import multi_timer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 2 + REGISTER_ADDRESS_WIDTH
);
    logic                     valid;
    logic                     ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [3:0]               wstrobe;
    logic [31:0]              wdata;
    logic [31:0]              rdata;

    modport master (
        output valid, address, wstrobe, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, address, wstrobe, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/multi_timer_channel.sv
// multi_timer_channel
// One timer channel: CONTROL, STATUS, REFILL and COUNT registers, the
// down-counter and (with MULTI_TIMER_PRESCALER_EN) an 8-bit prescaler.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   control_we/status_we/refill_we  decoded write enables from the top
//   wstrobe, wdata          byte enables and write data
//   control_value, status_value, refill_value, count_value  32-bit read views
//   irq                     irq_enable & event_flag
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        control_we,
    input  logic        status_we,
    input  logic        refill_we,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] control_value,
    output logic [31:0] status_value,
    output logic [31:0] refill_value,
    output logic [31:0] count_value,
    output logic        irq
);

    control_reg_t             control;
    control_reg_t             control_next;
    status_reg_t              status;
    logic [COUNTER_WIDTH-1:0] refill;
    logic [COUNTER_WIDTH-1:0] refill_next;
    logic [COUNTER_WIDTH-1:0] count;
    logic                     tick;
    logic                     start;
    logic                     rollover;

    // A start is decided by the written enable bit itself, so a write that
    // only touches the prescale byte does not restart a running channel.
    assign start    = control_we && wstrobe[0] && wdata[COUNT_ENABLE_BIT];
    assign rollover = tick && (count == '0);

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale_count;

    assign tick = control.count_enable && (prescale_count == control.prescale);

    // Restarting on every tick keeps P+1 enabled cycles between ticks and
    // covers the reset-on-reload case as well.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescale_count <= '0;
        end else if (start || tick) begin
            prescale_count <= '0;
        end else if (control.count_enable) begin
            prescale_count <= prescale_count + 1'b1;
        end
    end
`else
    assign tick = control.count_enable;
`endif

    always_comb begin
        control_next = control;
        if (wstrobe[0]) begin
            control_next.count_enable = wdata[COUNT_ENABLE_BIT];
            control_next.cyclic_mode  = wdata[CYCLIC_MODE_BIT];
            control_next.irq_enable   = wdata[IRQ_ENABLE_BIT];
        end
`ifdef MULTI_TIMER_PRESCALER_EN
        if (wstrobe[1]) begin
            control_next.prescale = wdata[PRESCALE_LSB +: PRESCALE_WIDTH];
        end
`else
        control_next.prescale = '0;
`endif
    end

    // Byte-lane merge limited to the implemented counter width
    always_comb begin
        refill_next = refill;
        for (int b = 0; b < COUNTER_WIDTH; b++) begin
            if (wstrobe[b / 8]) begin
                refill_next[b] = wdata[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            control <= '0;
            status  <= '0;
            refill  <= '0;
            count   <= '0;
        end else begin
            // A rollover outranks a same-cycle write-1-to-clear
            if (rollover) begin
                status.event_flag <= 1'b1;
            end else if (status_we && wstrobe[0] && wdata[EVENT_FLAG_BIT]) begin
                status.event_flag <= 1'b0;
            end

            if (refill_we) begin
                refill <= refill_next;
            end

            if (start) begin
                count <= refill;
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (control.cyclic_mode) begin
                    count <= refill;
                end
            end

            // A CONTROL write overrides the one-shot autoclear
            if (control_we) begin
                control <= control_next;
            end else if (rollover && !control.cyclic_mode) begin
                control.count_enable <= 1'b0;
            end
        end
    end

    assign control_value = control_to_word(control);
    assign status_value  = {31'b0, status.event_flag};
    assign refill_value  = 32'(refill);
    assign count_value   = 32'(count);
    assign irq           = control.irq_enable && status.event_flag;

endmodule

// File: rtl/multi_timer.sv
// multi_timer
// Multi-channel down-counting timer peripheral. Decodes the bus address into
// per-channel write enables, muxes read data and ORs the channel interrupts.
// Optional feature macro: MULTI_TIMER_PRESCALER_EN (per-channel prescaler).
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      register bus slave (valid/ready/address/wstrobe/wdata/rdata)
//   irq      level interrupt, OR of all enabled channel event flags
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    multi_timer_if.slave     bus,
    output logic             irq
);

    logic [31:0]         channel_index;
    local_address_t      register_select;
    logic                write;
    logic [31:0]         control_values [CHANNELS];
    logic [31:0]         status_values  [CHANNELS];
    logic [31:0]         refill_values  [CHANNELS];
    logic [31:0]         count_values   [CHANNELS];
    logic [CHANNELS-1:0] channel_irq;

    // Indices past the last channel match no instance, so they are
    // naturally write-ignored and read as zero.
    assign channel_index   = 32'(bus.address) >> REGISTER_ADDRESS_WIDTH;
    assign register_select = local_address_t'(bus.address[REGISTER_ADDRESS_WIDTH-1:0]);
    assign write           = bus.valid && (bus.wstrobe != 4'b0000);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        logic hit;
        assign hit = write && (channel_index == 32'(i));

        multi_timer_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_channel (
            .clk           (clk),
            .reset_n       (reset_n),
            .control_we    (hit && (register_select == CONTROL)),
            .status_we     (hit && (register_select == STATUS)),
            .refill_we     (hit && (register_select == REFILL)),
            .wstrobe       (bus.wstrobe),
            .wdata         (bus.wdata),
            .control_value (control_values[i]),
            .status_value  (status_values[i]),
            .refill_value  (refill_values[i]),
            .count_value   (count_values[i]),
            .irq           (channel_irq[i])
        );
    end

    // Read data comes straight from current register state, so a read in
    // the same cycle as a write returns the pre-write value.
    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (channel_index == 32'(i)) begin
                case (register_select)
                    CONTROL: bus.rdata = control_values[i];
                    STATUS:  bus.rdata = status_values[i];
                    REFILL:  bus.rdata = refill_values[i];
                    COUNT:   bus.rdata = count_values[i];
                    default: bus.rdata = '0;
                endcase
            end
        end
    end

    assign bus.ready = bus.valid;
    assign irq       = |channel_irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer
// Directed bench for multi_timer with 3 channels and an 8-bit counter, so
// channel index 3 is an out-of-range address. Expected values are hand
// computed; the prescaler step follows MULTI_TIMER_PRESCALER_EN.
module tb_multi_timer;
    import multi_timer_pkg::*;

    localparam int CHANNELS      = 3;
    localparam int COUNTER_WIDTH = 8;
    localparam int ADDRESS_WIDTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic irq;
    int   checks   = 0;
    int   failures = 0;

    multi_timer_if #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) bus ();

    multi_timer #(
        .CHANNELS      (CHANNELS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] addr_of(input int channel, input local_address_t r);
        logic [31:0] c;
        c = 32'(channel);
        return {c[1:0], r};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus write, taken on the next rising edge
    task automatic apply_stimulus(input logic [3:0] address, input logic [31:0] data,
                                  input logic [3:0] strobe);
        bus.valid   = 1'b1;
        bus.address = address;
        bus.wstrobe = strobe;
        bus.wdata   = data;
        @(posedge clk);
        #1;
        bus.valid   = 1'b0;
        bus.wstrobe = 4'b0000;
    endtask

    // Combinational read between edges; consumes no clock edge
    task automatic read_check(input string tag, input logic [3:0] address,
                              input logic [31:0] expected);
        bus.valid   = 1'b1;
        bus.address = address;
        bus.wstrobe = 4'b0000;
        #1;
        check_output(tag, bus.rdata, expected);
        bus.valid = 1'b0;
    endtask

    initial begin
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wstrobe = 4'b0000;
        bus.wdata   = '0;

        // Reset state
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        #1;
        check_output("reset_irq", 32'(irq), 32'd0);
        check_output("idle_ready", 32'(bus.ready), 32'd0);
        read_check("reset_control", addr_of(0, CONTROL), 32'h0);
        read_check("reset_status", addr_of(0, STATUS), 32'h0);
        read_check("reset_refill", addr_of(0, REFILL), 32'h0);
        read_check("reset_count", addr_of(0, COUNT), 32'h0);

        // One-shot on channel 1: REFILL=3, event exactly 4 cycles after start
        apply_stimulus(addr_of(1, REFILL), 32'd3, 4'hF);
        apply_stimulus(addr_of(1, CONTROL), 32'h1, 4'hF);
        read_check("oneshot_count_loaded", addr_of(1, COUNT), 32'd3);
        step(3);
        read_check("oneshot_status_early", addr_of(1, STATUS), 32'd0);
        read_check("oneshot_count_zero", addr_of(1, COUNT), 32'd0);
        step(1);
        read_check("oneshot_status_set", addr_of(1, STATUS), 32'd1);
        read_check("oneshot_autoclear", addr_of(1, CONTROL), 32'h0);
        read_check("oneshot_count_stays", addr_of(1, COUNT), 32'd0);
        check_output("oneshot_irq", 32'(irq), 32'd0);
        apply_stimulus(addr_of(1, STATUS), 32'd1, 4'hF);
        read_check("oneshot_w1c", addr_of(1, STATUS), 32'd0);

        // Cyclic with IRQ on channel 0: REFILL=2, events every 3 cycles
        apply_stimulus(addr_of(0, REFILL), 32'd2, 4'hF);
        apply_stimulus(addr_of(0, CONTROL), 32'h7, 4'hF);
        step(2);
        read_check("cyclic_status_early", addr_of(0, STATUS), 32'd0);
        check_output("cyclic_irq_early", 32'(irq), 32'd0);
        step(1);
        read_check("cyclic_event1", addr_of(0, STATUS), 32'd1);
        check_output("cyclic_irq1", 32'(irq), 32'd1);
        apply_stimulus(addr_of(0, STATUS), 32'd1, 4'hF);
        read_check("cyclic_cleared", addr_of(0, STATUS), 32'd0);
        check_output("cyclic_irq_dropped", 32'(irq), 32'd0);
        step(1);
        check_output("cyclic_irq_still_low", 32'(irq), 32'd0);
        step(1);
        check_output("cyclic_irq2", 32'(irq), 32'd1);
        read_check("cyclic_event2", addr_of(0, STATUS), 32'd1);

        // W1C landing on the rollover tick: set wins
        step(2);
        apply_stimulus(addr_of(0, STATUS), 32'd1, 4'hF);
        read_check("clear_vs_event", addr_of(0, STATUS), 32'd1);
        check_output("clear_vs_event_irq", 32'(irq), 32'd1);
        apply_stimulus(addr_of(0, STATUS), 32'd1, 4'hF);
        read_check("clear_after_event", addr_of(0, STATUS), 32'd0);
        apply_stimulus(addr_of(0, CONTROL), 32'h0, 4'hF);
        step(2);
        read_check("stopped_status", addr_of(0, STATUS), 32'd0);
        read_check("stopped_control", addr_of(0, CONTROL), 32'h0);
        check_output("stopped_irq", 32'(irq), 32'd0);

        // Read in the same cycle as a write returns the pre-write value
        bus.valid   = 1'b1;
        bus.address = addr_of(0, REFILL);
        bus.wstrobe = 4'hF;
        bus.wdata   = 32'd9;
        #1;
        check_output("read_during_write", bus.rdata, 32'd2);
        check_output("ready_follows_valid", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        bus.valid   = 1'b0;
        bus.wstrobe = 4'b0000;
        read_check("written_refill", addr_of(0, REFILL), 32'd9);

        // Width and byte strobes on channel 2
        apply_stimulus(addr_of(2, REFILL), 32'hFFFF_FF5A, 4'b0001);
        read_check("strobe_lane0", addr_of(2, REFILL), 32'h0000_005A);
        apply_stimulus(addr_of(2, REFILL), 32'h0000_A500, 4'b0010);
        read_check("strobe_above_width", addr_of(2, REFILL), 32'h0000_005A);
        apply_stimulus(addr_of(2, COUNT), 32'h33, 4'hF);
        read_check("count_write_ignored", addr_of(2, COUNT), 32'h0);
        apply_stimulus(addr_of(3, REFILL), 32'hFF, 4'hF);
        read_check("out_of_range_read", addr_of(3, REFILL), 32'h0);
        read_check("oor_no_alias_ch0", addr_of(0, REFILL), 32'd9);
        read_check("oor_no_alias_ch1", addr_of(1, REFILL), 32'd3);
        read_check("oor_no_alias_ch2", addr_of(2, REFILL), 32'h5A);
        apply_stimulus(addr_of(0, REFILL), 32'h77, 4'b0000);
        read_check("zero_strobe_is_read", addr_of(0, REFILL), 32'd9);

        // Prescaler: REFILL=1, CONTROL=0x0303 on channel 2
        apply_stimulus(addr_of(2, REFILL), 32'd1, 4'hF);
        apply_stimulus(addr_of(2, CONTROL), 32'h0303, 4'hF);
`ifdef MULTI_TIMER_PRESCALER_EN
        step(7);
        read_check("prescale_status_early", addr_of(2, STATUS), 32'd0);
        step(1);
        read_check("prescale_event", addr_of(2, STATUS), 32'd1);
        read_check("prescale_control", addr_of(2, CONTROL), 32'h0303);
`else
        step(1);
        read_check("prescale_status_early", addr_of(2, STATUS), 32'd0);
        step(1);
        read_check("prescale_event", addr_of(2, STATUS), 32'd1);
        read_check("prescale_control", addr_of(2, CONTROL), 32'h0003);
`endif
        check_output("prescale_irq_masked", 32'(irq), 32'd0);

        // Reset mid-count on channel 1
        apply_stimulus(addr_of(1, REFILL), 32'd5, 4'hF);
        apply_stimulus(addr_of(1, CONTROL), 32'h5, 4'hF);
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        read_check("midreset_control", addr_of(1, CONTROL), 32'h0);
        read_check("midreset_refill", addr_of(1, REFILL), 32'h0);
        read_check("midreset_count", addr_of(1, COUNT), 32'h0);
        read_check("midreset_ch2_control", addr_of(2, CONTROL), 32'h0);
        read_check("midreset_ch2_status", addr_of(2, STATUS), 32'h0);
        check_output("midreset_irq", 32'(irq), 32'd0);
        step(8);
        read_check("midreset_no_event", addr_of(1, STATUS), 32'd0);
        check_output("midreset_irq_after", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel down-counting timer peripheral for the Vermicel SoC bus. It provides `CHANNELS` independent channels, each with control, status, refill and count registers, configurable counter width, and a rollover event flag. It supports one-shot and cyclic modes and a write-1-to-clear event flag, and combines all channels into a single level-sensitive IRQ line. It replaces the single-channel timer in designs that need more than one time base.

## Interface
Parameters:
- `CHANNELS`, 4: number of timer channels, 1..16.
- `COUNTER_WIDTH`, 32: refill/count width, 1..32.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `valid`  in  1  bus request.
- `ready`  out  1  bus acknowledge.
- `address`  in  `$clog2(CHANNELS)+2`  word index: upper bits select the channel, low 2 bits select the register.
- `wstrobe`  in  4  byte write enables; all zero means a read.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data.
- `irq`  out  1  interrupt request, active high.

Clocking and reset (already decided): one clock, `clk`; reset is synchronous and active-low, `reset_n`.

## Operation
- Register map, per channel:
  - 0: CONTROL, RW. Bit 0 `count_enable` (autoclear), bit 1 `cyclic_mode`, bit 2 `irq_enable`, bits 15:8 `prescale` (see Configuration).
  - 1: STATUS, bit 0 `event_flag`. Reads the flag; writing 1 clears it.
  - 2: REFILL, RW.
  - 3: COUNT, RO.
- Writes:
  - A write occurs when `valid` is high and `wstrobe` is non-zero. Each byte lane is written only if its strobe bit is set.
  - Bits above `COUNTER_WIDTH` are ignored on write and read as 0.
  - Writes to COUNT are ignored.
  - Unused CONTROL bits read 0.
- Channel tick: occurs every cycle in which `count_enable` = 1 and the prescaler expires.
  - On a tick with count ≠ 0: count decrements by 1.
  - On a tick with count = 0: `event_flag` is set to 1. If `cyclic_mode` = 1, count reloads from REFILL. Otherwise `count_enable` clears to 0 and count stays at 0.
- Writing CONTROL with `count_enable` = 1 loads count from REFILL and restarts the prescaler. This happens even if the channel is already running.
- A REFILL write while running takes effect only at the next reload or start.
- Simultaneous events:
  - Event set and a W1C write on the same cycle: set wins, flag stays 1.
  - Autoclear and a CONTROL write on the same cycle: the write wins.
- `irq` = OR over all channels of (`irq_enable` & `event_flag`).
- Addresses whose channel index is ≥ `CHANNELS`: reads return 0, writes are ignored, and `ready` still responds.

## Timing
- `ready` = `valid`, combinational; zero-wait-state bus.
- `rdata` is combinational from `address` and current register state. A read in the same cycle as a write returns the pre-write value.
- Written values are visible from the next cycle.
- `irq` is registered-flag based: it asserts the cycle after the tick that sets `event_flag`, and deasserts the cycle after the clearing write.
- With REFILL = R, in cyclic mode with prescale 0, an event occurs every R+1 cycles. The first event is R+1 cycles after the start write.
- REFILL = 0 in cyclic mode: an event every tick.
- Reset values: all CONTROL fields, STATUS, REFILL and count = 0; `irq` = 0. `ready` and `rdata` follow their combinational definitions (0 when idle).
- Reset mid-count aborts the count immediately; no event is generated.

## Configuration
- `MULTI_TIMER_PRESCALER_EN` defined:
  - Each channel has an 8-bit prescale field P in CONTROL[15:8] and a prescaler counter.
  - A tick occurs every P+1 enabled cycles.
  - The prescaler counter resets to 0 on start and on reload.
- Not defined:
  - CONTROL[15:8] reads 0 and writes to it are ignored.
  - Every enabled cycle is a tick.
  - No prescaler flops are synthesised.

## Structure
- Package `multi_timer_pkg` contains:
  - register enum `local_address_t`: CONTROL, STATUS, REFILL, COUNT.
  - `REGISTER_ADDRESS_WIDTH` = 2.
  - packed structs `control_reg_t` (with `prescale`) and `status_reg_t`.
  - field bit positions.
- Sub-module `multi_timer_channel`: one instance per channel via a generate loop. It holds the registers, the counter and the prescaler, and takes decoded write enables. The top level does address decode, the read mux and the IRQ OR.

## Test plan
- One-shot: CHANNELS=4, channel 1, REFILL=3, CONTROL=0x1 → `event_flag` = 1 after exactly 4 cycles, `count_enable` reads 0, COUNT = 0, `irq` stays 0.
- Cyclic with IRQ: channel 0, REFILL=2, CONTROL=0x7 → events every 3 cycles and `irq` = 1. W1C STATUS=1 → `irq` drops the next cycle; it re-asserts at the following event.
- Simultaneous clear and event: W1C write on the exact tick that rolls over → `event_flag` remains 1.
- Width and strobes: COUNTER_WIDTH=8, write REFILL=0xFFFF_FF5A with `wstrobe`=0001 → REFILL reads 0x5A. A write to COUNT is ignored. Channel index ≥ CHANNELS reads 0.
- Prescaler (macro on): REFILL=1, CONTROL=0x0303 → first event after 8 cycles. With the macro off, the same writes give an event after 2 cycles and CONTROL reads 0x3.
- Reset mid-count: `reset_n`=0 for 1 cycle while running → all registers 0, `irq` = 0, no event afterwards.
